// File: rtl/set_job_arbiter.sv
// Round-robin sharing of one SET candidate-counting core between two requesters,
// with a one-cycle start pulse, a watchdog on the core result and job statistics.
module set_job_arbiter #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TW      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_central,
  input  logic [11:0] req0_radius,
  input  logic [1:0]  req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_central,
  input  logic [11:0] req1_radius,
  input  logic [1:0]  req1_mode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_candidate,
  output logic        rsp_timeout,
  output logic        core_en,
  output logic [23:0] core_central,
  output logic [11:0] core_radius,
  output logic [1:0]  core_mode,
  input  logic        core_busy,
  input  logic        core_valid,
  input  logic [7:0]  core_candidate,
  output logic [15:0] jobs_done,
  output logic [7:0]  timeouts
);

  localparam int unsigned CW = 24;
  localparam int unsigned RW = 12;
  localparam int unsigned MW = 2;
  localparam int unsigned KW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  logic [TW-1:0]   wd_q, wd_d;
  logic [CW-1:0]   central_q, central_d;
  logic [RW-1:0]   radius_q, radius_d;
  logic [MW-1:0]   mode_q, mode_d;
  logic [KW-1:0]   cand_q, cand_d;
  logic            to_q, to_d;
  logic [DW-1:0]   done_q, done_d;
  logic [OW-1:0]   tos_q, tos_d;
  logic            gnt_c, gnt_id_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      wd_q      <= '0;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      cand_q    <= '0;
      to_q      <= 1'b0;
      done_q    <= '0;
      tos_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      wd_q      <= wd_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      cand_q    <= cand_d;
      to_q      <= to_d;
      done_q    <= done_d;
      tos_q     <= tos_d;
    end
  end

  // Next-state, arbitration and strobes
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    wd_d      = wd_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    cand_d    = cand_q;
    to_d      = to_q;
    done_d    = done_q;
    tos_d     = tos_q;
    gnt_c     = 1'b0;
    gnt_id_c  = 1'b0;
    core_en   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!core_busy && (req0_valid || req1_valid)) begin
          gnt_c     = 1'b1;
          // On contention the requester that did not win last time goes first
          gnt_id_c  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          id_d      = gnt_id_c;
          central_d = gnt_id_c ? req1_central : req0_central;
          radius_d  = gnt_id_c ? req1_radius  : req0_radius;
          mode_d    = gnt_id_c ? req1_mode    : req0_mode;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_en = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_valid) begin
          cand_d  = core_candidate;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          cand_d  = '0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = S_IDLE;
          if (to_q) begin
            if (tos_q != {OW{1'b1}}) tos_d = tos_q + OW'(1);
          end else begin
            if (done_q != {DW{1'b1}}) done_d = done_q + DW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req0_ready    = gnt_c && !gnt_id_c && !rst;
  assign req1_ready    = gnt_c &&  gnt_id_c && !rst;
  assign rsp_id        = id_q;
  assign rsp_candidate = cand_q;
  assign rsp_timeout   = to_q;
  assign core_central  = central_q;
  assign core_radius   = radius_q;
  assign core_mode     = mode_q;
  assign jobs_done     = done_q;
  assign timeouts      = tos_q;

endmodule

// File: tb/tb_set_job_arbiter.sv
// Randomized bench for set_job_arbiter: a transaction-level reference model
// predicts grants, core starts, responses and counters every cycle.
module tb_set_job_arbiter;
  localparam int unsigned TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [23:0] req0_central, req1_central, core_central;
  logic [11:0] req0_radius, req1_radius, core_radius;
  logic [1:0]  req0_mode, req1_mode, core_mode;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_timeout;
  logic [7:0]  rsp_candidate, core_candidate, timeouts;
  logic        core_en, core_busy, core_valid;
  logic [15:0] jobs_done;

  set_job_arbiter #(.TIMEOUT(TIMEOUT), .TW(10)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_central(req0_central),
    .req0_radius(req0_radius), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_central(req1_central),
    .req1_radius(req1_radius), .req1_mode(req1_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_candidate(rsp_candidate), .rsp_timeout(rsp_timeout),
    .core_en(core_en), .core_central(core_central), .core_radius(core_radius),
    .core_mode(core_mode), .core_busy(core_busy), .core_valid(core_valid),
    .core_candidate(core_candidate), .jobs_done(jobs_done), .timeouts(timeouts)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs (percentages) and core responder settings
  int p0 = 0, p1 = 0, pbusy = 0, prdy = 100, pstray = 0, never_pct = 0;
  int lat_mode = 0;   // 0 random 1..12, >0 fixed latency, -1 never respond
  int cand_fix = -1;
  bit fix_pay = 1'b0;
  int cnt = 0;

  // Logs filled by the reference model
  bit         grant_log[$];
  logic [9:0] resp_log[$];   // {timeout, id, candidate}
  int         n_en = 0;

  function automatic bit rnd(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic step();
    int k;
    @(posedge clk);
    #1;
    req0_valid = rnd(p0);
    if (fix_pay) begin
      req0_central = 24'h444488;
      req0_radius  = 12'h333;
      req0_mode    = 2'b00;
    end else begin
      req0_central = 24'($urandom);
      req0_radius  = 12'($urandom);
      req0_mode    = 2'($urandom);
    end
    req1_valid   = rnd(p1);
    req1_central = 24'($urandom);
    req1_radius  = 12'($urandom);
    req1_mode    = 2'($urandom);
    core_busy    = rnd(pbusy);
    rsp_ready    = rnd(prdy);
    core_valid   = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        core_valid     = 1'b1;
        core_candidate = (cand_fix >= 0) ? 8'(cand_fix) : 8'($urandom);
      end
    end else if (rnd(pstray)) begin
      core_valid     = 1'b1;
      core_candidate = 8'($urandom);
    end
    if (core_en) begin
      if (lat_mode > 0)       k = lat_mode;
      else if (lat_mode < 0)  k = 0;
      else if (rnd(never_pct)) k = 0;
      else                    k = $urandom_range(12, 1);
      cnt = k;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cnt = 0;
    grant_log.delete();
    resp_log.delete();
  endtask

  // Reference model: job-level view of the arbiter, advanced once per cycle
  bit          m_open, m_en_due, m_wait, m_pend, m_last, m_id, m_to;
  int          m_cyc, m_wstart, m_done, m_tos;
  logic [7:0]  m_cand;
  logic [23:0] m_c;
  logic [11:0] m_r;
  logic [1:0]  m_m;

  always @(negedge clk) begin
    bit e0, e1;
    if (rst) begin
      m_open = 0; m_en_due = 0; m_wait = 0; m_pend = 0; m_last = 1'b1; m_id = 0;
      m_to = 0; m_cand = '0; m_done = 0; m_tos = 0; m_c = '0; m_r = '0; m_m = '0;
      check("ready0_in_rst", req0_ready, 0);
      check("ready1_in_rst", req1_ready, 0);
    end else begin
      e0 = !m_open && !core_busy && req0_valid && (!req1_valid || m_last);
      e1 = !m_open && !core_busy && req1_valid && (!req0_valid || !m_last);
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      check("ready_both", req0_ready & req1_ready, 0);
      check("core_en", core_en, m_en_due);
      check("core_central", core_central, m_c);
      check("core_radius", core_radius, m_r);
      check("core_mode", core_mode, m_m);
      check("rsp_valid", rsp_valid, m_pend);
      if (m_pend) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_candidate", rsp_candidate, m_cand);
        check("rsp_timeout", rsp_timeout, m_to);
      end
      check("jobs_done", jobs_done, m_done);
      check("timeouts", timeouts, m_tos);
      if (core_en) n_en++;
      if (m_pend && rsp_ready) begin
        resp_log.push_back({rsp_timeout, rsp_id, rsp_candidate});
        if (m_to) m_tos = (m_tos == 255) ? 255 : m_tos + 1;
        else      m_done = (m_done == 65535) ? 65535 : m_done + 1;
        m_last = m_id;
        m_open = 0;
        m_pend = 0;
      end
      if (m_wait) begin
        if (core_valid) begin
          m_pend = 1; m_cand = core_candidate; m_to = 0; m_wait = 0;
        end else if (m_cyc - m_wstart == int'(TIMEOUT) - 1) begin
          m_pend = 1; m_cand = '0; m_to = 1; m_wait = 0;
        end
      end
      if (m_en_due) begin
        m_en_due = 0; m_wait = 1; m_wstart = m_cyc + 1;
      end
      if (e0 || e1) begin
        m_open = 1; m_en_due = 1; m_id = e1;
        m_c = e1 ? req1_central : req0_central;
        m_r = e1 ? req1_radius  : req0_radius;
        m_m = e1 ? req1_mode    : req0_mode;
        grant_log.push_back(e1);
      end
    end
    m_cyc++;
  end

  initial begin
    int en0;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0; core_busy = 0; core_valid = 0;
    req0_central = '0; req0_radius = '0; req0_mode = '0;
    req1_central = '0; req1_radius = '0; req1_mode = '0; core_candidate = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_core_en", core_en, 0);
    check("rst_core_central", core_central, 0);
    check("rst_core_radius", core_radius, 0);
    check("rst_core_mode", core_mode, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_candidate", rsp_candidate, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_timeouts", timeouts, 0);

    // Single job from requester 0 with a fixed payload and latency
    fix_pay = 1; lat_mode = 5; cand_fix = 29; prdy = 100;
    en0 = n_en;
    p0 = 100; step(); p0 = 0;
    repeat (15) step();
    check("t1_en_pulses", 32'(n_en - en0), 1);
    check("t1_resp_count", 32'(resp_log.size()), 1);
    if (resp_log.size() > 0) check("t1_resp", resp_log[0], {1'b0, 1'b0, 8'd29});
    check("t1_jobs_done", jobs_done, 1);

    // Both requesters continuously valid: grants alternate starting with 0
    do_reset();
    fix_pay = 0; lat_mode = 0; cand_fix = -1;
    p0 = 100; p1 = 100;
    for (int i = 0; i < 200 && grant_log.size() < 4; i++) step();
    p0 = 0; p1 = 0;
    check("t2_grant_count", 32'(grant_log.size()), 4);
    repeat (30) step();
    if (grant_log.size() >= 4 && resp_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t2_grant_id", grant_log[i], i % 2);
        check("t2_rsp_id", resp_log[i][8], i % 2);
      end
    end else check("t2_resp_count", 32'(resp_log.size()), 4);

    // Core never answers: watchdog aborts the job
    do_reset();
    lat_mode = -1;
    p0 = 100; step(); p0 = 0;
    repeat (TIMEOUT + 15) step();
    check("t3_timeouts", timeouts, 1);
    check("t3_jobs_done", jobs_done, 0);
    check("t3_resp_count", 32'(resp_log.size()), 1);
    if (resp_log.size() > 0) check("t3_resp", resp_log[0], {1'b1, 1'b0, 8'd0});

    // Response held off by the consumer while requester 1 waits
    do_reset();
    lat_mode = 2;
    p0 = 100; step(); p0 = 0;
    prdy = 0; p1 = 100;
    repeat (25) step();
    check("t4_no_grant", 32'(grant_log.size()), 1);
    prdy = 100;
    repeat (3) step();
    p1 = 0;
    repeat (15) step();
    check("t4_grants", 32'(grant_log.size()), 2);

    // Busy core blocks the grant until it drops
    do_reset();
    pbusy = 100; p1 = 100;
    repeat (10) step();
    check("t5_busy_grants", 32'(grant_log.size()), 0);
    pbusy = 0;
    step();
    p1 = 0;
    step();
    check("t5_grant_after_busy", 32'(grant_log.size()), 1);
    repeat (20) step();

    // Reset while waiting on the core; the late core result must be ignored
    do_reset();
    fix_pay = 1; lat_mode = 10;
    p0 = 100; step(); p0 = 0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_core_central", core_central, 0);
    check("t6_jobs_done", jobs_done, 0);
    repeat (15) step();
    check("t6_resp_count", 32'(resp_log.size()), 0);

    // Randomized traffic
    do_reset();
    fix_pay = 0; lat_mode = 0; never_pct = 1; pstray = 3;
    p0 = 40; p1 = 40; pbusy = 25; prdy = 60;
    repeat (3000) step();
    p0 = 0; p1 = 0; pbusy = 0; prdy = 100; pstray = 0;
    repeat (TIMEOUT + 50) step();
    check("t7_all_answered", 32'(resp_log.size()), 32'(grant_log.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
